// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage; also used by main_decoder for pcsrc port typing.
package fetch_pkg;
   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      PCSRC_SEQ    = 2'b00,
      PCSRC_BRANCH = 2'b01,
      PCSRC_JALR   = 2'b10
   } pcsrc_t;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] p);
      return p + XLEN'(4);
   endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer between imem responses and decode; flush empties it in one cycle.
module fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int W     = 32,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [W-1:0]  o_data,
   output logic [CW-1:0] o_count,
   output logic          o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_rd, r_wr;
   logic [CW-1:0] r_count;
   logic          w_pop, w_full;

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_pop   = i_pop && (r_count != '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign o_data  = r_mem[r_rd];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= wrap_inc(r_wr);
         end
         if (w_pop) r_rd <= wrap_inc(r_rd);
         r_count <= r_count + CW'(i_push) - CW'(w_pop);
      end
   end

   // The issue credit makes this unreachable; firing means the credit accounting broke.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(i_push && w_full && !i_pop && !i_flush));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-order imem reads, buffered delivery to decode, redirect/flush.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect target sets misalign_err and halts fetch.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pcplus4,
   input  logic [1:0]      pcsrc,
   input  logic [XLEN-1:0] immext,
   input  logic [XLEN-1:0] aluresult,
   output logic            misalign_err
);
   localparam int          CW      = $clog2(BUF_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

   fetch_state_t    r_state, w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc, r_head_pc, w_target_raw, w_target, w_head_data;
   logic [CW-1:0]   r_outstanding, r_discard, w_count;
   logic [CW:0]     w_inflight;
   logic            w_empty, w_accept, w_redirect, w_misalign, w_rsp, w_push, w_issue;

   assign w_accept   = instr_valid && instr_ready;
   assign w_redirect = w_accept && (pcsrc == PCSRC_BRANCH || pcsrc == PCSRC_JALR);
   assign w_target_raw = (pcsrc == PCSRC_JALR) ? (aluresult & ~32'h1) : (r_head_pc + immext);

`ifdef FETCH_MISALIGN_CHECK_EN
   logic r_misalign_err;
   assign w_misalign   = w_redirect && (w_target_raw[1:0] != 2'b00);
   assign w_target     = w_target_raw;
   assign misalign_err = r_misalign_err;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_misalign_err <= 1'b0;
      else if (w_misalign) r_misalign_err <= 1'b1;
   end
`else
   assign w_misalign   = 1'b0;
   assign w_target     = w_target_raw & ~32'h3;
   assign misalign_err = 1'b0;
`endif

   // Responses are meaningless in BOOT (anything arriving belongs to a pre-reset request).
   assign w_rsp      = imem_rvalid && (r_state != BOOT) && (r_outstanding != '0);
   assign w_push     = w_rsp && (r_discard == '0) && !w_redirect && (r_state == RUN);
   assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_count};

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         BOOT: w_state_nxt = RUN;
         RUN: begin
            w_issue = !w_redirect && (w_inflight < DEPTH_C);
            if (w_misalign) w_state_nxt = HALT;
         end
         default: w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= BOOT;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_head_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_rsp);
         if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_head_pc  <= w_target;
            // Everything still in flight after this edge is stale.
            r_discard  <= r_outstanding - CW'(w_rsp);
         end else begin
            if (w_issue)  r_fetch_pc <= pc_next(r_fetch_pc);
            if (w_accept) r_head_pc  <= pc_next(r_head_pc);
            if (w_rsp && r_discard != '0) r_discard <= r_discard - 1'b1;
         end
      end
   end

   fetch_buffer #(.DEPTH(BUF_DEPTH), .W(XLEN)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (imem_rdata),
      .i_pop   (w_accept),
      .i_flush (w_redirect),
      .o_data  (w_head_data),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign imem_req    = w_issue;
   assign imem_addr   = r_fetch_pc;
   assign instr_valid = (r_state == RUN) && !w_empty;
   assign instr       = w_empty ? '0 : w_head_data;
   assign pc          = r_head_pc;
   assign pcplus4     = pc_next(r_head_pc);
endmodule
